// File: rtl/csr_pkg.sv
// Shared CSR definitions: modify codes, CSR addresses, the UART
// receiver state encoding and the status-bit modify helper.
package csr_pkg;

    typedef enum logic [2:0] {
        MOD_NONE  = 3'd0,
        MOD_WRITE = 3'd1,
        MOD_SET   = 3'd2,
        MOD_CLEAR = 3'd3
    } mod_e;

    localparam logic [11:0] CSR_UART      = 12'hbc0;
    localparam logic [11:0] CSR_UART_STAT = 12'hbc1;
    localparam logic [11:0] CSR_SIM       = 12'h3ff;

    localparam logic [31:0] RX_EOF = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAITHI
    } rx_state_e;

    // Applies a CSR modify code to a group of writable bits.
    function automatic logic [1:0] csr_apply(
        input logic [2:0] m,
        input logic [1:0] cur,
        input logic [1:0] w
    );
        logic [1:0] r;
        r = cur;
        case (m)
            MOD_WRITE: r = w;
            MOD_SET:   r = cur | w;
            MOD_CLEAR: r = cur & ~w;
            default:   r = cur;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/csr_uart_rx_if.sv
// CSR bus between pipeline (master) and a CSR responder (slave).
// Ports: read, modify[2:0], wdata[31:0], addr[11:0] -> rdata[31:0], valid.
interface csr_uart_rx_if;

    logic        read;
    logic [2:0]  modify;
    logic [31:0] wdata;
    logic [11:0] addr;
    logic [31:0] rdata;
    logic        valid;

    modport master (
        output read,
        output modify,
        output wdata,
        output addr,
        input  rdata,
        input  valid
    );

    modport slave (
        input  read,
        input  modify,
        input  wdata,
        input  addr,
        output rdata,
        output valid
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// Byte FIFO for the UART receiver, depth 2**FIFO_LOG2.
// Ports: clk, rstn, push/din, pop/dout, full, empty, count.
module uart_rx_fifo #(
    parameter int FIFO_LOG2 = 2,
    parameter int WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WIDTH-1:0]     din,
    output logic [WIDTH-1:0]     dout,
    output logic                 full,
    output logic                 empty,
    output logic [FIFO_LOG2:0]   count
);

    localparam int DEPTH = 1 << FIFO_LOG2;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [FIFO_LOG2:0] wptr;
    logic [FIFO_LOG2:0] rptr;
    logic               do_pop;
    logic               do_push;

    assign empty = (wptr == rptr);
    // Pointers carry one extra wrap bit: full when only that bit differs.
    assign full  = ((wptr ^ rptr) == {1'b1, {FIFO_LOG2{1'b0}}});
    assign count = wptr - rptr;
    assign dout  = mem[rptr[FIFO_LOG2-1:0]];

    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[FIFO_LOG2-1:0]] <= din;
    end

endmodule

// File: rtl/csr_uart_rx.sv
// CSR-mapped 8N1 UART receiver with byte FIFO and status register.
// Ports: clk, rstn, bus (CSR slave), rx (serial in), irq (FIFO non-empty).
module csr_uart_rx
    import csr_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR   = CSR_UART,
    parameter int          CLK_PER_BIT = 868,
    parameter int          FIFO_LOG2   = 2
) (
    input  logic          clk,
    input  logic          rstn,
    csr_uart_rx_if.slave  bus,
    input  logic          rx,
    output logic          irq
);

    localparam int TW = $clog2(CLK_PER_BIT);
    localparam int CW = FIFO_LOG2 + 1;
    localparam logic [TW-1:0] T_HALF = TW'(CLK_PER_BIT / 2);
    localparam logic [TW-1:0] T_FULL = TW'(CLK_PER_BIT - 1);
    localparam logic [11:0] STAT_ADDR = BASE_ADDR + 12'd1;

    // Synchroniser and start-edge qualification
    logic       rx_meta;
    logic       rx_s;
    logic [1:0] sync_ok;
    logic       armed;

    // Receiver FSM
    rx_state_e  state;
    rx_state_e  state_nxt;
    logic [TW-1:0] timer;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       expired;
    logic       ld_half;
    logic       ld_full;
    logic       do_shift;
    logic       stop_ok;
    logic       stop_bad;
    logic       push_q;

    // FIFO
    logic          pop;
    logic          full;
    logic          empty;
    logic [7:0]    head;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          push_ok;
    logic          ovr_set;

    // CSR
    logic [11:0] addr_q;
    logic        ferr;
    logic        ovr;
    logic [1:0]  flags_nxt;
    logic        rd_data_hit;
    logic        rd_stat_hit;
    logic        mod_hit;
    logic [3:0]  cnt4;
    logic [31:0] status;
    logic [31:0] rdata_nxt;
    logic        unused_wdata;

    assign unused_wdata = ^{bus.wdata[31:3], bus.wdata[0]};

    // The synchroniser resets high; sync_ok keeps that preload from
    // counting as a genuine idle level on the pin.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            sync_ok <= 2'b00;
            armed   <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            sync_ok <= {sync_ok[0], 1'b1};
            armed   <= (state == IDLE) && rx_s && sync_ok[1];
        end
    end

    assign expired = (timer == '0);

    always_comb begin
        state_nxt = state;
        ld_half   = 1'b0;
        ld_full   = 1'b0;
        do_shift  = 1'b0;
        stop_ok   = 1'b0;
        stop_bad  = 1'b0;
        unique case (state)
            IDLE: begin
                if (armed && !rx_s) begin
                    state_nxt = START;
                    ld_half   = 1'b1;
                end
            end
            START: begin
                if (expired) begin
                    if (rx_s) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DATA;
                        ld_full   = 1'b1;
                    end
                end
            end
            DATA: begin
                if (expired) begin
                    do_shift = 1'b1;
                    ld_full  = 1'b1;
                    if (bit_cnt == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                if (expired) begin
                    if (rx_s) begin
                        stop_ok   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        stop_bad  = 1'b1;
                        state_nxt = WAITHI;
                    end
                end
            end
            WAITHI: begin
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            timer   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            push_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            push_q <= stop_ok;
            if (ld_half)
                timer <= T_HALF;
            else if (ld_full)
                timer <= T_FULL;
            else if (!expired)
                timer <= timer - 1'b1;
            if (ld_half)
                bit_cnt <= '0;
            else if (do_shift)
                bit_cnt <= bit_cnt + 1'b1;
            if (do_shift)
                shreg <= {rx_s, shreg[7:1]};
        end
    end

    assign rd_data_hit = bus.read && (bus.addr == BASE_ADDR);
    assign rd_stat_hit = bus.read && (bus.addr == STAT_ADDR);
    assign pop         = rd_data_hit && !empty;

    uart_rx_fifo #(
        .FIFO_LOG2 (FIFO_LOG2),
        .WIDTH     (8)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push_q),
        .pop   (pop),
        .din   (shreg),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign push_ok   = push_q && (!full || pop);
    assign ovr_set   = push_q && full && !pop;
    assign count_nxt = count + CW'(push_ok) - CW'(pop);

    // Modify lands one cycle after its address.
    assign mod_hit = (addr_q == STAT_ADDR);

    always_comb begin
        flags_nxt = {ferr, ovr};
        if (mod_hit)
            flags_nxt = csr_apply(bus.modify, {ferr, ovr}, bus.wdata[2:1]);
        // Hardware events override a same-cycle clear.
        flags_nxt = flags_nxt | {stop_bad, ovr_set};
    end

    assign cnt4   = 4'(count);
    assign status = {24'b0, cnt4, 1'b0, ferr, ovr, !empty};

    always_comb begin
        rdata_nxt = '0;
        unique case (1'b1)
            rd_data_hit: rdata_nxt = empty ? RX_EOF : {24'b0, head};
            rd_stat_hit: rdata_nxt = status;
            default:     rdata_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q    <= '0;
            ferr      <= 1'b0;
            ovr       <= 1'b0;
            bus.rdata <= '0;
            bus.valid <= 1'b0;
            irq       <= 1'b0;
        end else begin
            addr_q    <= bus.addr;
            ferr      <= flags_nxt[1];
            ovr       <= flags_nxt[0];
            bus.rdata <= rdata_nxt;
            bus.valid <= rd_data_hit || rd_stat_hit;
            irq       <= (count_nxt != '0);
        end
    end

endmodule

// File: tb/tb_csr_uart_rx.sv
// Scoreboard bench for csr_uart_rx: serial frames on rx, CSR reads
// checked by a monitor against queued expectations.
module tb_csr_uart_rx;
    import csr_pkg::*;

    localparam int CPB = 8;
    localparam logic [11:0] BASE = 12'hbc0;
    localparam logic [11:0] STAT = 12'hbc1;

    logic clk;
    logic rstn;
    logic rx;
    logic irq;

    int checks;
    int errors;

    logic [31:0] exp_q[$];
    string       nm_q[$];

    csr_uart_rx_if bus();

    csr_uart_rx #(
        .BASE_ADDR   (BASE),
        .CLK_PER_BIT (CPB),
        .FIFO_LOG2   (2)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus),
        .rx   (rx),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn && bus.valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid got %h want none",
                         bus.rdata);
            end else begin
                automatic logic [31:0] e = exp_q.pop_front();
                automatic string n = nm_q.pop_front();
                check(n, bus.rdata, e);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
        rx = 1'b1;
    endtask

    task automatic csr_read(input string nm, input logic [11:0] a,
                            input logic [31:0] exp);
        exp_q.push_back(exp);
        nm_q.push_back(nm);
        bus.read = 1'b1;
        bus.addr = a;
        @(negedge clk);
        bus.read = 1'b0;
        bus.addr = '0;
    endtask

    task automatic csr_mod(input logic [11:0] a, input logic [2:0] code,
                           input logic [31:0] d);
        bus.addr = a;
        @(negedge clk);
        bus.addr   = '0;
        bus.modify = code;
        bus.wdata  = d;
        @(negedge clk);
        bus.modify = MOD_NONE;
        bus.wdata  = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        rstn = 1'b0;
        rx = 1'b1;
        bus.read = 1'b0;
        bus.modify = MOD_NONE;
        bus.wdata = '0;
        bus.addr = '0;
        idle(3);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        rstn = 1'b1;
        idle(4);

        send_frame(8'h55, 1'b1);
        idle(4);
        check("irq_after_55", 32'(irq), 32'd1);
        csr_read("rd_55", BASE, 32'h0000_0055);
        check("irq_after_pop", 32'(irq), 32'd0);

        csr_read("rd_eof", BASE, 32'hFFFF_FFFF);
        csr_read("stat_empty", STAT, 32'h0000_0000);

        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(20);
        check("glitch_irq", 32'(irq), 32'd0);
        check("glitch_idle", 32'(dut.state), 32'(IDLE));
        csr_read("glitch_stat", STAT, 32'h0000_0000);

        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        idle(4);
        csr_read("ovr_stat", STAT, 32'h0000_0043);
        csr_read("ovr_rd1", BASE, 32'h0000_0001);
        csr_read("ovr_rd2", BASE, 32'h0000_0002);
        csr_read("ovr_rd3", BASE, 32'h0000_0003);
        csr_read("ovr_rd4", BASE, 32'h0000_0004);
        csr_read("ovr_eof", BASE, 32'hFFFF_FFFF);
        csr_mod(STAT, MOD_CLEAR, 32'h6);
        csr_read("ovr_clr", STAT, 32'h0000_0000);

        send_frame(8'hA5, 1'b0);
        rx = 1'b1;
        idle(6);
        check("ferr_irq", 32'(irq), 32'd0);
        csr_read("ferr_stat", STAT, 32'h0000_0004);
        csr_mod(STAT, MOD_CLEAR, 32'h6);
        csr_read("ferr_clr", STAT, 32'h0000_0000);
        csr_mod(STAT, MOD_SET, 32'h2);
        csr_read("mod_set", STAT, 32'h0000_0002);
        csr_mod(STAT, MOD_WRITE, 32'h4);
        csr_read("mod_write", STAT, 32'h0000_0004);
        csr_mod(BASE, MOD_WRITE, 32'h0);
        csr_read("mod_data_reg", STAT, 32'h0000_0004);
        csr_mod(STAT, MOD_CLEAR, 32'hFFFF_FFFF);
        csr_read("mod_clr_all", STAT, 32'h0000_0000);

        for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1);
        idle(4);
        csr_read("full_stat", STAT, 32'h0000_0041);
        fork
            send_frame(8'h14, 1'b1);
            begin
                repeat (80) @(negedge clk);
                csr_read("coinc_rd", BASE, 32'h0000_0010);
            end
        join
        idle(4);
        csr_read("coinc_stat", STAT, 32'h0000_0041);
        for (int i = 1; i <= 4; i++)
            csr_read("coinc_drain", BASE, 32'h10 + 32'(i));
        csr_read("coinc_eof", BASE, 32'hFFFF_FFFF);

        send_frame(8'h77, 1'b1);
        idle(4);
        check("pre_rst_irq", 32'(irq), 32'd1);
        fork
            send_frame(8'h00, 1'b1);
            begin
                repeat (30) @(negedge clk);
                rstn = 1'b0;
                idle(3);
                rstn = 1'b1;
            end
        join
        idle(4);
        check("midrst_irq", 32'(irq), 32'd0);
        check("midrst_idle", 32'(dut.state), 32'(IDLE));
        csr_read("midrst_stat", STAT, 32'h0000_0000);
        csr_read("midrst_eof", BASE, 32'hFFFF_FFFF);
        send_frame(8'h3C, 1'b1);
        idle(4);
        csr_read("rd_3c", BASE, 32'h0000_003C);
        csr_read("final_stat", STAT, 32'h0000_0000);

        idle(5);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/csr_uart_rx.md
Name: csr_uart_rx

Overview:
- CSR-mapped UART receiver. It is the inbound counterpart of the UART transmit path at CSR 0xbc0.
- Deserialises 8N1 frames from the `rx` pin into a small FIFO.
- Answers CSR reads from the pipeline as a CSR-bus responder, in the same way as the counter, pins and timer CSR blocks.
- Its `rdata`/`valid` are OR-ed into the SoC CSR return bus.

Parameters:
- BASE_ADDR, 12'hbc0, data register address; the status register is at BASE_ADDR+1.
- CLK_PER_BIT, 868, clock cycles per bit (100 MHz / 115200); minimum 4.
- FIFO_LOG2, 2, log2 of the FIFO depth (default depth 4).

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rstn  in  1  reset; asynchronous assert, active-low.
- read  in  1  CSR read strobe, qualified by `addr` in the same cycle.
- modify  in  3  CSR modify code, one cycle after `addr`: 1 = write, 2 = set bits, 3 = clear bits, other codes = none.
- wdata  in  32  CSR write operand, same cycle as `modify`.
- addr  in  12  CSR address.
- rdata  out  32  read data, one cycle after `read`; zero when not selected.
- valid  out  1  high one cycle after `read` with a matching `addr`.
- rx  in  1  serial input, idle high, asynchronous to clk.
- irq  out  1  high while the FIFO is non-empty.

Behaviour:
- Reset values (all asynchronous on rstn low):
  - rdata = 0, valid = 0, irq = 0.
  - FIFO empty, pointers = 0.
  - Status flags = 0.
  - FSM in IDLE.
  - Synchroniser flops = 1.
- Input synchroniser: `rx` passes through 2 flops (`rx_s`). An edge on the pin reaches `rx_s` 2 cycles later.
- Receiver FSM, bit counter 0..7, timer 0..CLK_PER_BIT-1:
  - IDLE: when `rx_s` = 0, load timer with CLK_PER_BIT/2 and go to START.
  - START: on timer expiry, if `rx_s` = 1 (false start) go to IDLE; otherwise reload CLK_PER_BIT and go to DATA.
  - DATA: on each expiry, shift `rx_s` in LSB-first. After the 8th bit go to STOP.
  - STOP:
    - `rx_s` = 1: push the byte and go to IDLE.
    - `rx_s` = 0: set FERR, discard the byte, go to WAITHI.
  - WAITHI: stay until `rx_s` = 1, then go to IDLE. A break condition therefore produces exactly one FERR and no pushes.
- Timer expiry is the cycle in which the timer is 0.
- The FIFO push happens in the cycle after the stop-bit sample.
- FIFO:
  - Depth 2^FIFO_LOG2.
  - Pointers are FIFO_LOG2+1 bits wide and wrap naturally.
  - Full: pointers differ only in the MSB. Empty: pointers are equal.
- CSR cycle N: `read` = 1 and `addr` = BASE_ADDR. The following happen in cycle N+1:
  - `valid` = 1.
  - If the FIFO is non-empty: `rdata` = {24'b0, head byte}, and the head is popped.
  - If the FIFO is empty: `rdata` = 32'hFFFF_FFFF (EOF) and nothing is popped.
- CSR cycle N: `read` = 1 and `addr` = BASE_ADDR+1. In cycle N+1, `valid` = 1 and `rdata` = {24'b0, count[3:0], 1'b0, FERR, OVR, non-empty}.
- CSR modify:
  - Only the status register is modified, and only bits 2:1 (FERR, OVR). All other bits ignore writes.
  - The modify applies in cycle N+1 and uses the address registered in cycle N.
  - Modify code 1 writes the bits, code 2 sets them, code 3 clears them.
  - Modifying the data register has no effect.
- Simultaneous events:
  - Push and pop in the same cycle: both happen and the count is unchanged. This includes a full FIFO, where the push succeeds because of the pop.
  - Push while full with no pop: the byte is dropped and OVR is set.
  - A hardware set of FERR/OVR and a CSR clear in the same cycle: the set wins.
- `irq` is registered and equals "non-empty" after the current update.
- Reset asserted mid-frame: the FSM goes to IDLE, the partial byte is lost and the FIFO is emptied. After release, no frame is accepted until `rx_s` has been seen high in IDLE; IDLE requires a 1→0 transition, not a low level.

Decomposition:
- Shared package `csr_pkg`:
  - Modify codes: MOD_NONE = 0, MOD_WRITE = 1, MOD_SET = 2, MOD_CLEAR = 3.
  - CSR address constants: CSR_UART = 12'hbc0, CSR_UART_STAT = 12'hbc1 for the UART build variant; CSR_SIM = 12'h3ff.
  - Receiver state enum: IDLE, START, DATA, STOP, WAITHI.
- One natural sub-module, `uart_rx_fifo`: parameterised by FIFO_LOG2, with push/pop/full/empty/count outputs. The FSM and the CSR decode stay in the top module.

Test Plan (CLK_PER_BIT = 8, FIFO_LOG2 = 2):
- Send 0x55, then read BASE_ADDR → `valid` 1 cycle later, `rdata` = 0x00000055, `irq` goes 1 → 0.
- Read BASE_ADDR with the FIFO empty → `rdata` = 0xFFFFFFFF. Read status → `rdata` = 0x00000000.
- 3-cycle low glitch on `rx` → no push, FSM back in IDLE, `irq` stays 0.
- Send 0x01..0x05 with no reads → status = 0x00000043 (count 4, OVR, non-empty); reads return 0x01, 0x02, 0x03, 0x04, then 0xFFFFFFFF.
- Stop bit driven 0 with data 0xA5 → FERR set (status = 0x04), no push. Then modify = 3 with `wdata` = 0x6 → status = 0x00000000.
- FIFO full and a read pop coincides with the next push cycle → count stays 4, OVR stays 0. Assert rstn low mid-frame → `irq` = 0, status = 0, and the next clean frame 0x3C is received correctly.
